// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment patterns, digit codes and scan-decoder state encodings.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {ST_COLLECT, ST_CONVERT, ST_REPORT} state_t;

    function automatic logic has_invalid(input logic [15:0] bcd);
        return bcd[3:0] == DIGIT_INVALID || bcd[7:4] == DIGIT_INVALID ||
               bcd[11:8] == DIGIT_INVALID || bcd[15:12] == DIGIT_INVALID;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-high 7-segment pattern to {valid, digit}; blank reads as 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        digit = DIGIT_INVALID;
        case (pattern)
            SEG_0, SEG_BLANK: digit = 4'd0;
            SEG_1:            digit = 4'd1;
            SEG_2:            digit = 4'd2;
            SEG_3:            digit = 4'd3;
            SEG_4:            digit = 4'd4;
            SEG_5:            digit = 4'd5;
            SEG_6:            digit = 4'd6;
            SEG_7:            digit = 4'd7;
            SEG_8:            digit = 4'd8;
            SEG_9:            digit = 4'd9;
            default:          valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the value shown on a multiplexed 4-digit 7-segment display
// by debouncing each scanned digit, collecting a frame and converting it to binary.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [13:0] value,
    output logic        value_valid,
    output logic        frame_err,
    output logic [15:0] digits_bcd
);

    logic [6:0]  seg_h;
    logic [3:0]  an_h;
    logic [10:0] prev;
    logic [7:0]  cnt;
    logic        one_hot;
    logic        same;
    logic        capture;
    logic [1:0]  pos;
    logic        dec_valid;
    logic [3:0]  dec_digit;
    logic [3:0]  code;
    logic [15:0] buffer;
    logic [15:0] snap;
    logic [3:0]  mask;
    logic [13:0] acc;
    logic [13:0] acc_next;
    logic [1:0]  idx;
    logic        frame_done;
    state_t      state;

    assign seg_h      = SEG_ACTIVE_LOW != 0 ? ~seg : seg;
    assign an_h       = AN_ACTIVE_LOW != 0 ? ~an : an;
    assign one_hot    = an_h != 4'd0 && (an_h & (an_h - 4'd1)) == 4'd0;
    assign same       = {an_h, seg_h} == prev;
    assign capture    = one_hot && same && cnt == 8'(STABLE_CYCLES - 1);
    assign pos        = {an_h[3] | an_h[2], an_h[3] | an_h[1]};
    assign code       = dec_valid ? dec_digit : DIGIT_INVALID;
    assign frame_done = state == ST_COLLECT && mask == 4'hF;
    assign acc_next   = 14'(acc * 14'd10) + {10'd0, snap[{idx, 2'b00} +: 4]};

    seg7_pattern_decode u_decode (
        .pattern (seg_h),
        .valid   (dec_valid),
        .digit   (dec_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            digits_bcd  <= '0;
            prev        <= '0;
            cnt         <= '0;
            buffer      <= '0;
            snap        <= '0;
            mask        <= '0;
            acc         <= '0;
            idx         <= '0;
            state       <= ST_COLLECT;
        end else begin
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            prev        <= {an_h, seg_h};
            cnt         <= !one_hot ? 8'd0 :
                           (!same || cnt == 8'd0) ? 8'd1 :
                           cnt == 8'(STABLE_CYCLES) ? cnt : cnt + 8'd1;
            // A capture coinciding with the frame hand-off belongs to the next frame.
            mask        <= (frame_done ? 4'h0 : mask) | (capture ? an_h : 4'h0);
            if (capture)
                buffer[{pos, 2'b00} +: 4] <= code;
            if (frame_done) begin
                state <= ST_CONVERT;
                snap  <= buffer;
                acc   <= '0;
                idx   <= 2'd3;
            end else if (state == ST_CONVERT) begin
                acc <= acc_next;
                idx <= idx - 2'd1;
                if (idx == 2'd0) begin
                    state      <= ST_REPORT;
                    digits_bcd <= snap;
                    if (has_invalid(snap)) begin
                        frame_err <= 1'b1;
                    end else begin
                        value       <= acc_next;
                        value_valid <= 1'b1;
                    end
                end
            end else if (state == ST_REPORT) begin
                state <= ST_COLLECT;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: table-driven frame scans with a pulse scoreboard, plus glitch and reset sequences.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic [13:0] value;
    logic        value_valid;
    logic        frame_err;
    logic [15:0] digits_bcd;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [27:0] pats;
        int          hold;
        logic [1:0]  kind;
        logic [13:0] exp_value;
        logic [15:0] exp_bcd;
    } frame_t;

    typedef struct {
        logic [1:0]  kind;
        logic [13:0] value;
        logic [15:0] bcd;
    } exp_t;

    exp_t   sb[$];
    frame_t frames[10];

    seg7_scan_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .value_valid (value_valid),
        .frame_err   (frame_err),
        .digits_bcd  (digits_bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic show(input int p, input logic [6:0] pat, input int hold);
        an  = ~(4'(1 << p));
        seg = ~pat;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [27:0] pats, input int hold);
        for (int p = 0; p < 4; p++) show(p, pats[p*7 +: 7], hold);
    endtask

    task automatic idle(input int n);
        an  = 4'hF;
        seg = 7'h7F;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (value_valid || frame_err) begin
            if (value_valid && frame_err) begin
                total++;
                $display("FAIL pulse_exclusive: valid=%b err=%b both high", value_valid, frame_err);
            end
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_pulse: valid=%b err=%b value=%0d bcd=%h", value_valid, frame_err, value, digits_bcd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {14'd0, frame_err, value_valid}, {14'd0, e.kind});
                chk("pulse_value", {2'b0, value}, {2'b0, e.value});
                chk("pulse_bcd", digits_bcd, e.bcd);
            end
        end
    end

    initial begin
        //                thousands  hundreds  tens      ones
        frames[0] = '{{7'h06, 7'h5B, 7'h4F, 7'h66}, 8, 2'd1, 14'd1234, 16'h1234};
        frames[1] = '{{7'h6F, 7'h6F, 7'h6F, 7'h6F}, 8, 2'd1, 14'd9999, 16'h9999};
        frames[2] = '{{7'h00, 7'h00, 7'h00, 7'h07}, 8, 2'd1, 14'd7,    16'h0007};
        frames[3] = '{{7'h79, 7'h6D, 7'h7D, 7'h07}, 8, 2'd2, 14'd7,    16'hF567};
        frames[4] = '{{7'h7F, 7'h7F, 7'h7F, 7'h7F}, 3, 2'd0, 14'd0,    16'h0000};
        frames[5] = '{{7'h3F, 7'h6D, 7'h7D, 7'h3F}, 4, 2'd1, 14'd560,  16'h0560};
        frames[6] = '{{7'h66, 7'h4F, 7'h5B, 7'h06}, 4, 2'd1, 14'd4321, 16'h4321};
        frames[7] = '{{7'h7F, 7'h3F, 7'h7F, 7'h3F}, 4, 2'd1, 14'd8080, 16'h8080};
        frames[8] = '{{7'h06, 7'h3F, 7'h01, 7'h06}, 4, 2'd2, 14'd8080, 16'h10F1};
        frames[9] = '{{7'h7F, 7'h07, 7'h7D, 7'h6D}, 5, 2'd1, 14'd8765, 16'h8765};

        #12;
        chk("reset_value", {2'b0, value}, 16'd0);
        chk("reset_valid", {15'd0, value_valid}, 16'd0);
        chk("reset_err", {15'd0, frame_err}, 16'd0);
        chk("reset_bcd", digits_bcd, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 10; i++) begin
            if (frames[i].kind != 2'd0)
                sb.push_back('{frames[i].kind, frames[i].exp_value, frames[i].exp_bcd});
            scan(frames[i].pats, frames[i].hold);
        end
        idle(20);
        chk("table_drained", 16'(sb.size()), 16'd0);

        // Each digit broken by an all-anodes-on glitch: no run reaches the threshold.
        for (int p = 0; p < 4; p++) begin
            show(p, 7'h6D, 3);
            an = 4'b0000;
            @(posedge clk);
            #1;
            show(p, 7'h6D, 3);
        end
        idle(20);
        chk("glitch_value_held", {2'b0, value}, 16'd8765);

        // Abandon a frame two cycles into conversion.
        for (int p = 0; p < 3; p++) show(p, 7'h4F, 8);
        show(3, 7'h4F, 4);
        an  = 4'hF;
        seg = 7'h7F;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_value", {2'b0, value}, 16'd0);
        chk("midrst_valid", {15'd0, value_valid}, 16'd0);
        chk("midrst_err", {15'd0, frame_err}, 16'd0);
        chk("midrst_bcd", digits_bcd, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(15);
        chk("midrst_no_pulse_value", {2'b0, value}, 16'd0);

        sb.push_back('{2'd1, 14'd2468, 16'h2468});
        scan({7'h5B, 7'h66, 7'h7D, 7'h7F}, 8);
        idle(20);
        chk("final_drained", 16'(sb.size()), 16'd0);
        chk("final_value", {2'b0, value}, 16'd2468);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required to accept a digit (legal range 2..255).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means segment inputs are active-low.
REQ-003 SHALL have parameter AN_ACTIVE_LOW, default 1: 1 means anode inputs are active-low.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 seg  input  7  multiplexed segment lines; seg[0]=a through seg[6]=g.
REQ-007 an  input  4  digit anode lines; an[0]=ones digit through an[3]=thousands digit.
REQ-008 value  output  14  last successfully decoded display value, binary, 0..9999.
REQ-009 value_valid  output  1  one-cycle pulse when value updates.
REQ-010 frame_err  output  1  one-cycle pulse when a completed frame holds an undecodable digit.
REQ-011 digits_bcd  output  16  last completed frame as BCD, [3:0]=ones; an undecodable digit reads 4'hF.

Function
REQ-012 SHALL normalise seg and an to active-high internally per SEG_ACTIVE_LOW / AN_ACTIVE_LOW.
REQ-013 SHALL treat a sample as candidate only when the normalised an is exactly one-hot; any other an (zero or multi-hot) SHALL clear the stability counter.
REQ-014 SHALL count consecutive cycles with unchanged {an, seg}; any change SHALL restart the count at 1.
REQ-015 SHALL capture a digit exactly once per stable run, on the cycle the count reaches STABLE_CYCLES; the counter SHALL saturate until {an, seg} changes.
REQ-016 Decode table (active-high, hex): 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 00 (blank)=0; any other pattern SHALL be stored as invalid (4'hF).
REQ-017 Captured digits SHALL go into a 4-entry collect buffer with a 4-bit captured mask; recapture of an already-captured position SHALL overwrite it.
REQ-018 State machine COLLECT -> CONVERT when mask == 4'b1111; on that transition the buffer SHALL be snapshotted and mask cleared in the same cycle.
REQ-019 CONVERT SHALL take exactly 4 cycles: acc = acc*10 + digit, thousands first, acc cleared at entry.
REQ-020 CONVERT -> REPORT after 4th cycle; REPORT SHALL last 1 cycle then return to COLLECT.
REQ-021 In REPORT with no invalid digit in snapshot: value <= acc, digits_bcd <= snapshot, value_valid = 1.
REQ-022 In REPORT with any invalid digit: value unchanged, digits_bcd <= snapshot, frame_err = 1.
REQ-023 value_valid and frame_err SHALL never assert together; latency from 4th capture to pulse SHALL be 5 cycles.
REQ-024 Digit capture SHALL continue during CONVERT/REPORT into the cleared collect buffer for the next frame.
REQ-025 A capture on the same cycle as the COLLECT->CONVERT transition SHALL land in the new (cleared) buffer.

Reset
REQ-026 rst_n low SHALL immediately force: value=0, value_valid=0, frame_err=0, digits_bcd=16'h0000, mask=0, counter=0, state=COLLECT.
REQ-027 Reset asserted mid-CONVERT SHALL abandon the frame with no pulse after release.

Structure
REQ-028 Segment pattern constants, the 4'hF invalid code and state encodings SHALL live in shared package seg7_pkg, reused by seg7_driver.
REQ-029 SHALL contain one sub-module seg7_pattern_decode: combinational 7-bit pattern to {valid, 4-bit digit}.

Verification
REQ-030 Scan "1234" (an active-low one-hot, 8 cycles/digit, ones first) -> value_valid pulse, value=1234, digits_bcd=16'h1234.
REQ-031 Scan "9999" -> value=9999 (14'h270F); then scan blank,blank,blank,"7" -> value=7.
REQ-032 Thousands pattern 7'h79 ("E") -> frame_err pulse, value holds prior, digits_bcd[15:12]=4'hF.
REQ-033 Each digit held only STABLE_CYCLES-1 cycles, or an=4'b0000 active-low glitch mid-run -> no capture, no pulse.
REQ-034 rst_n low 2 cycles into CONVERT -> all outputs 0, no pulse after release; next full scan decodes normally.
REQ-035 Back-to-back frames at minimum 4*STABLE_CYCLES cycles each -> every frame reported, none lost.
